fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter FIFO_WORD_SIZE, default 10, data word width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, depth of the drained FIFO (power of 2).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of rd_count.
REQ-004 SHALL have ports, one clock, reset asynchronous and active-high:
  clk  input  1  rising-edge clock
  reset  input  1  asynchronous, active-high reset
  init  input  1  configuration phase; holds block in INIT
  fifo_data  input  FIFO_WORD_SIZE  FIFO data_out, valid one edge after fifo_rd_en sampled
  fifo_empty  input  1  FIFO empty flag
  fifo_error  input  1  FIFO error flag
  fifo_rd_en  output  1  read strobe to FIFO
  data_out  output  FIFO_WORD_SIZE  head word to downstream
  valid_out  output  1  data_out valid
  ready_in  input  1  downstream accepts data_out
  idle  output  1  high in IDLE with nothing buffered or in flight
  err  output  1  sticky error indication
  rd_count  output  CNT_WIDTH  words delivered (REQ-019)

Function
REQ-005 SHALL implement FSM states INIT, IDLE, ACTIVE, ERROR.
REQ-006 INIT: stays while init=1; init=0 -> IDLE next edge.
REQ-007 IDLE: fifo_empty=0 -> ACTIVE next edge; fifo_rd_en=0 in IDLE.
REQ-008 ACTIVE: fifo_rd_en=1 iff fifo_empty=0 and (buf_count + inflight - pop) < 2, where pop = valid_out & ready_in.
REQ-009 inflight: 1-bit flag set at edge where fifo_rd_en=1; at next edge fifo_data captured into 2-entry buffer, inflight cleared unless new read issued.
REQ-010 Read-to-output latency: fifo_rd_en high in cycle c -> word visible on data_out/valid_out in cycle c+2 when buffer empty.
REQ-011 ACTIVE -> IDLE when fifo_empty=1, inflight=0, buf_count=0.
REQ-012 Buffer: 2-entry, in-order; data_out = head entry; valid_out = (buf_count != 0); simultaneous capture and pop keep count unchanged.
REQ-013 data_out/valid_out SHALL hold stable while valid_out=1 and ready_in=0.
REQ-014 fifo_error=1 in any state except INIT -> ERROR next edge; err=1 from that edge.
REQ-015 ERROR: fifo_rd_en=0, valid_out=0, buffer discarded; exit only via init=1 (-> INIT) or reset.
REQ-016 init=1 in IDLE/ACTIVE/ERROR -> INIT next edge, buffer and inflight flushed, err cleared.
REQ-017 Sustained throughput SHALL be one word per cycle with ready_in=1 and FIFO non-empty.

Reset
REQ-018 reset=1 SHALL immediately force: state INIT, fifo_rd_en=0, valid_out=0, data_out=0, idle=0, err=0, buf_count=0, inflight=0, rd_count=0; mid-transfer data discarded, no partial word output.

Configuration
REQ-019 Macro FIFO_READER_COUNT_EN: defined -> rd_count increments by 1 on each pop, wraps at 2^CNT_WIDTH, cleared by reset or INIT; undefined -> rd_count tied to 0, no counter logic.

Structure
REQ-020 Shared package fifo_pkg SHALL hold state enum type, FIFO_WORD_SIZE/FIFO_DEPTH defaults, buffer depth constant 2.
REQ-021 Sub-module fifo_reader_skid (2-entry buffer, count, head mux) SHALL be instantiated once; FSM and credit logic in fifo_reader.

Verification
REQ-022 Reset, init 1 cycle then 0, FIFO empty -> INIT then IDLE, idle=1, fifo_rd_en never 1.
REQ-023 FIFO preloaded 8 words 0x001..0x008, ready_in=1 -> first valid_out 2 cycles after first fifo_rd_en, 0x001..0x008 on 8 consecutive cycles, then IDLE; rd_count=8 with macro.
REQ-024 Same load, ready_in=0 for 5 cycles -> at most 2 reads issued, data_out=0x001 held stable, no loss/reorder after ready_in=1.
REQ-025 fifo_error pulse after 3rd word -> ERROR next edge, err=1, valid_out=0, fifo_rd_en=0 until init=1.
REQ-026 reset asserted asynchronously mid-burst (word 0x004 in flight) -> all outputs 0 before next edge; after release/init, remaining words 0x005.. delivered first.
REQ-027 Build without FIFO_READER_COUNT_EN -> REQ-023 repeated, rd_count=0 throughout.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the FIFO reader
package fifo_pkg;

    localparam int FIFO_WORD_SIZE_DEF = 10;
    localparam int FIFO_DEPTH_DEF     = 8;
    localparam int BUF_DEPTH          = 2;
    localparam int BUF_CNT_W          = 2;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        ERROR  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// rtl/fifo_reader_skid.sv - 2-entry in-order holding buffer with head mux
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WORD_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_data,
    output logic [BUF_CNT_W-1:0] count,
    output logic                 valid
);

    logic [WIDTH-1:0]     mem [BUF_DEPTH];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [BUF_CNT_W-1:0] cnt;
    logic                 do_push;
    logic                 do_pop;

    // An empty buffer cannot be popped; a full one only accepts a word when the head leaves in the same cycle.
    assign do_pop  = pop && (cnt != '0) && !flush;
    assign do_push = push && !flush && ((cnt < BUF_CNT_W'(BUF_DEPTH)) || do_pop);

    // Storage array: written without reset, content is qualified by cnt.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush discards everything buffered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + BUF_CNT_W'(1);
                2'b01:   cnt <= cnt - BUF_CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Head word is forced to zero when nothing is buffered so a reset never exposes stale data.
    always_comb begin
        valid     = (cnt != '0);
        head_data = valid ? mem[rd_ptr] : '0;
        count     = cnt;
    end

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - drains a FIFO into a ready/valid stream; FIFO_READER_COUNT_EN enables rd_count
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int FIFO_WORD_SIZE = FIFO_WORD_SIZE_DEF,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [FIFO_WORD_SIZE-1:0] fifo_data,
    input  logic                      fifo_empty,
    input  logic                      fifo_error,
    output logic                      fifo_rd_en,
    output logic [FIFO_WORD_SIZE-1:0] data_out,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic                      idle,
    output logic                      err,
    output logic [CNT_WIDTH-1:0]      rd_count
);

    if (FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_reader: FIFO_DEPTH must be a power of two");
    end

    state_t               state;
    state_t               state_nxt;
    logic                 inflight;
    logic                 rd_en;
    logic                 flush;
    logic                 pop;
    logic                 buf_valid;
    logic [BUF_CNT_W-1:0] buf_count;
    logic [BUF_CNT_W:0]   occupancy;

    assign pop        = valid_out & ready_in;
    assign valid_out  = buf_valid;
    assign fifo_rd_en = rd_en;
    assign idle       = (state == IDLE) && (buf_count == '0) && !inflight;

    // Words already owned by this block after this cycle: buffered plus in flight minus the one leaving.
    assign occupancy = {1'b0, buf_count} + {{BUF_CNT_W{1'b0}}, inflight} - {{BUF_CNT_W{1'b0}}, pop};

    fifo_reader_skid #(
        .WIDTH (FIFO_WORD_SIZE)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (pop),
        .head_data (data_out),
        .count     (buf_count),
        .valid     (buf_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, read strobe and flush; init outranks a FIFO error, which outranks normal reading.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        flush     = 1'b0;
        case (state)
            INIT: begin
                flush = 1'b1;
                if (!init) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (init) begin
                    state_nxt = INIT;
                    flush     = 1'b1;
                end else if (fifo_error) begin
                    state_nxt = ERROR;
                    flush     = 1'b1;
                end else if (!fifo_empty) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (init) begin
                    state_nxt = INIT;
                    flush     = 1'b1;
                end else if (fifo_error) begin
                    state_nxt = ERROR;
                    flush     = 1'b1;
                end else begin
                    rd_en = !fifo_empty && (occupancy < (BUF_CNT_W + 1)'(BUF_DEPTH));
                    if (fifo_empty && !inflight && (buf_count == '0)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            ERROR: begin
                flush = 1'b1;
                if (init) begin
                    state_nxt = INIT;
                end
            end
            default: begin
                state_nxt = INIT;
                flush     = 1'b1;
            end
        endcase
    end

    // A read issued this cycle returns its word next cycle, when the skid buffer captures it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
        end else if (flush) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
        end
    end

    // Sticky error: set on entering ERROR, held there, cleared once init takes the block back to INIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= (state_nxt == ERROR);
        end
    end

`ifdef FIFO_READER_COUNT_EN
    // Delivered-word counter, wraps naturally at its width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
        end else if (state == INIT) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + CNT_WIDTH'(1);
        end
    end
`else
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - scoreboard bench for fifo_reader
module tb_fifo_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic [9:0]  fifo_data = '0;
    logic        fifo_empty;
    logic        fifo_error;
    logic        fifo_rd_en;
    logic [9:0]  data_out;
    logic        valid_out;
    logic        ready_in;
    logic        idle;
    logic        err;
    logic [15:0] rd_count;

    int checks = 0;
    int errors = 0;
    int delivered = 0;
    logic [9:0] exp_q [$];

    logic [9:0] fmem [64];
    int         f_wr = 0;
    int         f_rd = 0;
    logic       fifo_flush = 1'b0;

    always #5 clk = ~clk;

    fifo_reader #(
        .FIFO_WORD_SIZE (10),
        .FIFO_DEPTH     (8),
        .CNT_WIDTH      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_error (fifo_error),
        .fifo_rd_en (fifo_rd_en),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .idle       (idle),
        .err        (err),
        .rd_count   (rd_count)
    );

    // FIFO model: data_out valid one edge after fifo_rd_en is sampled.
    assign fifo_empty = (f_rd == f_wr);
    always @(posedge clk) begin
        if (fifo_flush) begin
            f_rd <= f_wr;
        end else if (fifo_rd_en && (f_rd != f_wr)) begin
            fifo_data <= fmem[f_rd % 64];
            f_rd      <= f_rd + 1;
        end
    end

    // Monitor: every accepted word must match the scoreboard head.
    always @(negedge clk) begin
        if (reset === 1'b0 && valid_out === 1'b1 && ready_in === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_word unexpected word %h, scoreboard empty", data_out);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL stream_word got %h expected %h", data_out, e);
                end
            end
            delivered++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load8();
        for (int i = 1; i <= 8; i++) begin
            fmem[f_wr % 64] = 10'(i);
            f_wr = f_wr + 1;
            exp_q.push_back(10'(i));
        end
    endtask

    task automatic pulse_init();
        @(negedge clk) init = 1'b1;
        @(negedge clk) init = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!(idle === 1'b1 && exp_q.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(nm, (n < 300) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int first_rd, first_v, last_v, vcnt, reads, stable, nz, bad, d0, n;
        logic [31:0] exp_cnt;

        reset      = 1'b1;
        init       = 1'b0;
        fifo_error = 1'b0;
        ready_in   = 1'b0;

        // Reset state
        #2;
        check("reset_rd_en", fifo_rd_en, 0);
        check("reset_valid", valid_out, 0);
        check("reset_data", data_out, 0);
        check("reset_idle", idle, 0);
        check("reset_err", err, 0);
        check("reset_count", rd_count, 0);

        // Init pulse with empty FIFO: INIT then IDLE, never a read
        @(negedge clk) reset = 1'b0;
        @(negedge clk) init = 1'b1;
        @(negedge clk);
        check("init_idle_low", idle, 0);
        init = 1'b0;
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_rd_en) reads++;
        end
        check("empty_idle", idle, 1);
        check("empty_no_reads", reads, 0);

        // Streaming 8 words with ready_in high
        ready_in = 1'b1;
        load8();
        first_rd = -1; first_v = -1; last_v = -1; vcnt = 0; nz = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (fifo_rd_en && first_rd < 0) first_rd = i;
            if (valid_out) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                vcnt++;
            end
`ifndef FIFO_READER_COUNT_EN
            if (rd_count != 0) nz++;
`endif
            if (idle && exp_q.size() == 0 && vcnt > 0) break;
        end
        check("burst_latency", first_v - first_rd, 2);
        check("burst_words", vcnt, 8);
        check("burst_contiguous", last_v - first_v, 7);
        check("burst_idle", idle, 1);
`ifdef FIFO_READER_COUNT_EN
        exp_cnt = 32'd8;
`else
        exp_cnt = 32'd0;
`endif
        check("burst_rd_count", rd_count, exp_cnt);
        check("burst_count_zero_run", nz, 0);

        // Back-pressure: ready_in low, at most two words pulled, head held
        ready_in = 1'b0;
        load8();
        reads = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_rd_en) reads++;
        end
        check("bp_reads", reads, 2);
        check("bp_valid", valid_out, 1);
        check("bp_head", data_out, 10'h001);
        stable = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (valid_out === 1'b1 && data_out === 10'h001 && fifo_rd_en === 1'b0) stable++;
        end
        check("bp_stable", stable, 4);
        ready_in = 1'b1;
        wait_idle("bp_drain");

        // FIFO error after the third word
        load8();
        d0 = delivered;
        n = 0;
        while (delivered < d0 + 3 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("err_third_word_seen", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        fifo_error = 1'b1;
        @(negedge clk);
        #1 fifo_error = 1'b0;
        check("err_flag", err, 1);
        check("err_valid", valid_out, 0);
        check("err_rd_en", fifo_rd_en, 0);
        exp_q.delete();
        fifo_flush = 1'b1;
        @(negedge clk) fifo_flush = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (err !== 1'b1 || valid_out !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
        end
        check("err_sticky", bad, 0);
        pulse_init();
        @(negedge clk);
        check("err_cleared", err, 0);
        check("err_back_idle", idle, 1);

        // Asynchronous reset while word 0x004 is in flight
        load8();
        d0 = delivered;
        n = 0;
        while (!(fifo_rd_en === 1'b1 && f_rd == f_wr - 5) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_found_word4", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_async_rd_en", fifo_rd_en, 0);
        check("rst_async_valid", valid_out, 0);
        check("rst_async_data", data_out, 0);
        check("rst_async_idle", idle, 0);
        check("rst_async_err", err, 0);
        check("rst_async_count", rd_count, 0);
        check("rst_delivered_before", delivered - d0, 2);
        exp_q.delete();
        for (int i = 5; i <= 8; i++) exp_q.push_back(10'(i));
        @(negedge clk) reset = 1'b0;
        pulse_init();
        wait_idle("rst_resume_drain");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
